// File: rtl/buzzer_pkg.sv
// Shared types and constants for the buzzer arbiter.
// Build option BUZZER_PREEMPT_EN (see buzzer_arbiter) does not affect this file.
package buzzer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } buzz_state_t;

  localparam int HP_W_DEF  = 24;
  localparam int DUR_W_DEF = 16;

  // Tone half-periods in 100 MHz clock cycles.
  localparam int NOTE_C5 = 95557;
  localparam int NOTE_A4 = 113636;
  localparam int NOTE_A5 = 56818;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int ctr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/buzzer_tone_gen.sv
// Square-wave tone generator: toggles the output every half_period cycles
// while enabled. Output and counter are held at 0 whenever en is low, so each
// tone starts from a low level. A zero half-period produces silence.
module buzzer_tone_gen
  import buzzer_pkg::*;
#(
  parameter int HP_W = HP_W_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_en,
  input  logic [HP_W-1:0] i_half_period,
  output logic            o_pwm_out
);

  logic [HP_W-1:0] r_cnt;
  logic            r_pwm;

  // Half-period counter and output toggle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_pwm <= 1'b0;
    end else if (!i_en) begin
      r_cnt <= '0;
      r_pwm <= 1'b0;
    end else if (i_half_period != '0) begin
      if (r_cnt == i_half_period - HP_W'(1)) begin
        r_cnt <= '0;
        r_pwm <= ~r_pwm;
      end else begin
        r_cnt <= r_cnt + HP_W'(1);
      end
    end
  end

  assign o_pwm_out = r_pwm;

endmodule

// File: rtl/buzzer_arbiter.sv
// Fixed-priority buzzer arbiter. Picks the lowest-index requester, latches its
// tone half-period and duration, plays the tone for dur ms, then holds a
// silent gap of GAP_MS ms before serving the next request.
// Build option: define BUZZER_PREEMPT_EN to let a higher-priority request
// abort the tone in progress (no gap is inserted after an abort).
module buzzer_arbiter
  import buzzer_pkg::*;
#(
  parameter int NUM_REQ  = 3,
  parameter int HP_W     = HP_W_DEF,
  parameter int DUR_W    = DUR_W_DEF,
  parameter int TICK_DIV = 100000,
  parameter int GAP_MS   = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [NUM_REQ*HP_W-1:0]  i_half_period,
  input  logic [NUM_REQ*DUR_W-1:0] i_dur_ms,
  output logic [NUM_REQ-1:0]       o_ack,
  output logic [NUM_REQ-1:0]       o_grant,
  output logic [NUM_REQ-1:0]       o_done,
  output logic                     o_busy,
  output logic                     o_pwm_out
);

  localparam int               PS_W     = ctr_width(TICK_DIV);
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(TICK_DIV - 1);
  localparam logic [DUR_W-1:0] GAP_LAST = DUR_W'(GAP_MS - 1);

  buzz_state_t        r_state;
  buzz_state_t        w_state_nxt;

  logic [NUM_REQ-1:0] r_ack;
  logic [NUM_REQ-1:0] r_grant;
  logic [NUM_REQ-1:0] r_done;
  logic [HP_W-1:0]    r_hp;
  logic [DUR_W-1:0]   r_dur;
  logic [PS_W-1:0]    r_presc;
  logic [DUR_W-1:0]   r_ms;

  logic [NUM_REQ-1:0] w_win;
  logic [HP_W-1:0]    w_win_hp;
  logic [DUR_W-1:0]   w_win_dur;
  logic               w_tick;
  logic               w_play_end;
  logic               w_gap_end;
  logic               w_tone_en;
`ifdef BUZZER_PREEMPT_EN
  logic               w_preempt;
`endif

  // Priority encoder: the lowest set request index wins; its fields are muxed out.
  always_comb begin
    w_win     = '0;
    w_win_hp  = '0;
    w_win_dur = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        w_win     = '0;
        w_win[i]  = 1'b1;
        w_win_hp  = i_half_period[i*HP_W +: HP_W];
        w_win_dur = i_dur_ms[i*DUR_W +: DUR_W];
      end
    end
  end

  assign w_tick     = (r_presc == PS_LAST);
  // A zero duration still spends one cycle in PLAY so ack and done never overlap.
  assign w_play_end = (r_dur == '0) || (w_tick && (r_ms == r_dur - DUR_W'(1)));
  assign w_gap_end  = w_tick && (r_ms == GAP_LAST);

`ifdef BUZZER_PREEMPT_EN
  // Any request below the granted index outranks it (grant is one-hot).
  assign w_preempt  = |(i_req & (r_grant - NUM_REQ'(1)));
`endif

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (|i_req) w_state_nxt = PLAY;
      end
      PLAY: begin
`ifdef BUZZER_PREEMPT_EN
        if (w_preempt)       w_state_nxt = IDLE;
        else if (w_play_end) w_state_nxt = GAP;
`else
        if (w_play_end)      w_state_nxt = GAP;
`endif
      end
      GAP: begin
        if (w_gap_end) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Request latching, handshake pulses and ms timing.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ack   <= '0;
      r_grant <= '0;
      r_done  <= '0;
      r_hp    <= '0;
      r_dur   <= '0;
      r_presc <= '0;
      r_ms    <= '0;
    end else begin
      r_ack  <= '0;
      r_done <= '0;
      case (r_state)
        IDLE: begin
          if (w_state_nxt == PLAY) begin
            r_ack   <= w_win;
            r_grant <= w_win;
            r_hp    <= w_win_hp;
            r_dur   <= w_win_dur;
            r_presc <= '0;
            r_ms    <= '0;
          end
        end
        PLAY: begin
          if (w_state_nxt != PLAY) begin
            r_done  <= r_grant;
            r_grant <= '0;
            r_presc <= '0;
            r_ms    <= '0;
          end else if (w_tick) begin
            r_presc <= '0;
            r_ms    <= r_ms + DUR_W'(1);
          end else begin
            r_presc <= r_presc + PS_W'(1);
          end
        end
        GAP: begin
          if (w_tick) begin
            r_presc <= '0;
            r_ms    <= r_ms + DUR_W'(1);
          end else begin
            r_presc <= r_presc + PS_W'(1);
          end
        end
        default: begin
          r_grant <= '0;
        end
      endcase
    end
  end

  // Tone runs only while PLAY continues, so the exit edge already drives pwm low.
  assign w_tone_en = (r_state == PLAY) && (w_state_nxt == PLAY);

  buzzer_tone_gen #(
    .HP_W (HP_W)
  ) u_tone (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_en          (w_tone_en),
    .i_half_period (r_hp),
    .o_pwm_out     (o_pwm_out)
  );

  assign o_ack   = r_ack;
  assign o_grant = r_grant;
  assign o_done  = r_done;
  assign o_busy  = (r_state != IDLE);

endmodule

// File: tb/tb_buzzer_arbiter.sv
// Directed bench for buzzer_arbiter. Expected per-cycle outputs
// {ack, grant, done, busy, pwm} are queued when a request is driven and
// popped as the DUT runs. Honors BUZZER_PREEMPT_EN for the preemption case.
module tb_buzzer_arbiter;

  localparam int NR      = 3;
  localparam int HPW     = 24;
  localparam int DW      = 16;
  localparam int TD      = 10;
  localparam int GM      = 1;
  localparam int GAP_CYC = GM * TD;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NR-1:0]    req = '0;
  logic [NR*HPW-1:0] hp_bus = '0;
  logic [NR*DW-1:0] dur_bus = '0;
  logic [NR-1:0]    ack, grant, done;
  logic             busy, pwm;

  typedef struct {
    int            cyc;
    logic [NR-1:0] r;
  } ev_t;

  logic [10:0] exp_q[$];
  ev_t         ev_q[$];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  buzzer_arbiter #(
    .NUM_REQ  (NR),
    .HP_W     (HPW),
    .DUR_W    (DW),
    .TICK_DIV (TD),
    .GAP_MS   (GM)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_req         (req),
    .i_half_period (hp_bus),
    .i_dur_ms      (dur_bus),
    .o_ack         (ack),
    .o_grant       (grant),
    .o_done        (done),
    .o_busy        (busy),
    .o_pwm_out     (pwm)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_field(input int idx, input int hp, input int dur);
    hp_bus[idx*HPW +: HPW] = HPW'(hp);
    dur_bus[idx*DW +: DW]  = DW'(dur);
  endtask

  task automatic push_play(input int idx, input int hp, input int n);
    logic [NR-1:0] oh;
    logic [NR-1:0] a;
    logic          p;
    oh = NR'(1) << idx;
    for (int k = 0; k < n; k++) begin
      a = (k == 0) ? oh : '0;
      p = (hp == 0) ? 1'b0 : (((k / hp) % 2) == 1);
      exp_q.push_back({a, oh, 3'b000, 1'b1, p});
    end
  endtask

  task automatic push_gap(input int idx);
    logic [NR-1:0] oh;
    oh = NR'(1) << idx;
    for (int g = 0; g < GAP_CYC; g++)
      exp_q.push_back({3'b000, 3'b000, (g == 0) ? oh : 3'b000, 1'b1, 1'b0});
  endtask

  task automatic push_idle(input logic [NR-1:0] d);
    exp_q.push_back({3'b000, 3'b000, d, 1'b0, 1'b0});
  endtask

  task automatic push_tone(input int idx, input int hp, input int dur);
    push_play(idx, hp, (dur == 0) ? 1 : dur * TD);
    push_gap(idx);
    push_idle('0);
  endtask

  task automatic add_ev(input int c, input logic [NR-1:0] r);
    ev_t e;
    e.cyc = c;
    e.r   = r;
    ev_q.push_back(e);
  endtask

  // Compare one queued expectation per cycle; apply req changes scheduled for that cycle.
  task automatic drain(input string tag);
    int c;
    c = 0;
    while (exp_q.size() > 0) begin
      while (ev_q.size() > 0 && ev_q[0].cyc == c) begin
        req = ev_q[0].r;
        void'(ev_q.pop_front());
      end
      check($sformatf("%s_c%0d", tag, c), {21'd0, ack, grant, done, busy, pwm}, {21'd0, exp_q.pop_front()});
      c++;
      step();
    end
    ev_q.delete();
  endtask

  initial begin
    #1;
    check("reset_outputs", {27'd0, ack, grant, done, busy, pwm}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("idle_after_reset", {27'd0, ack, grant, done, busy, pwm}, 32'd0);

    // 1: basic tone hp=4, dur=2
    set_field(0, 4, 2);
    req = 3'b001;
    step();
    push_tone(0, 4, 2);
    add_ev(0, 3'b000);
    drain("t1");

    // 2: simultaneous req[0] and req[2]; req[2] waits through the gap
    set_field(0, 2, 1);
    set_field(2, 3, 1);
    req = 3'b101;
    step();
    push_tone(0, 2, 1);
    push_tone(2, 3, 1);
    add_ev(0, 3'b100);
    add_ev(TD + GAP_CYC + 1, 3'b000);
    drain("t2");

    // 3: rest (hp=0) for 3 ms
    set_field(1, 0, 3);
    req = 3'b010;
    step();
    push_tone(1, 0, 3);
    add_ev(0, 3'b000);
    drain("t3");

    // 4: zero duration
    set_field(1, 4, 0);
    req = 3'b010;
    step();
    push_tone(1, 4, 0);
    add_ev(0, 3'b000);
    drain("t4");

    // 5: async reset at PLAY cycle 7 with req held, then re-ack
    set_field(0, 4, 2);
    req = 3'b001;
    step();
    for (int k = 0; k < 7; k++) step();
    check("t5_pre_reset", {27'd0, ack, grant, done, busy, pwm}, {27'd0, 3'b000, 3'b001, 3'b000, 1'b1, 1'b1});
    rst_n = 1'b0;
    #1;
    check("t5_async_reset", {27'd0, ack, grant, done, busy, pwm}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    push_tone(0, 4, 2);
    add_ev(0, 3'b000);
    drain("t5_reack");

    // 6: req[0] arrives while req[2] is playing
    set_field(2, 2, 1);
    set_field(0, 3, 1);
    req = 3'b100;
    step();
`ifdef BUZZER_PREEMPT_EN
    push_play(2, 2, 6);
    push_idle(3'b100);
    push_tone(0, 3, 1);
    add_ev(0, 3'b000);
    add_ev(5, 3'b001);
    add_ev(7, 3'b000);
`else
    push_tone(2, 2, 1);
    push_tone(0, 3, 1);
    add_ev(0, 3'b000);
    add_ev(5, 3'b001);
    add_ev(TD + GAP_CYC + 1, 3'b000);
`endif
    drain("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
